// File: rtl/map_position_ctrl.sv
// Sprite/map centre position controller: samples direction buttons once per
// frame at the vsync falling edge and moves x/y with a ramping, clamped speed.
module map_position_ctrl #(
  parameter logic [15:0] X_INIT       = 16'd512,
  parameter logic [15:0] Y_INIT       = 16'd384,
  parameter logic [15:0] X_MIN        = 16'd35,
  parameter logic [15:0] X_MAX        = 16'd988,
  parameter logic [15:0] Y_MIN        = 16'd25,
  parameter logic [15:0] Y_MAX        = 16'd742,
  parameter logic [3:0]  STEP_MAX     = 4'd8,
  parameter logic [3:0]  ACCEL_FRAMES = 4'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        hold,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic        frame_tick,
  output logic        moving
);

  typedef enum logic [1:0] {IDLE, MOVING, HOLD} state_t;

  state_t      state, state_nx;
  logic        vsync_d, tick;
  logic [3:0]  speed, speed_nx, fcnt, fcnt_nx;
  logic [15:0] x_nx, y_nx;
  logic        xinc, xdec, yinc, ydec;
  logic [16:0] x_sum, y_sum, x_lo, y_lo;

  assign tick = vsync_d & ~vsync;
  assign xinc = right & ~left;
  assign xdec = left & ~right;
  assign yinc = down & ~up;
  assign ydec = up & ~down;

  // 17-bit sums so the clamp tests cannot wrap
  assign x_sum = {1'b0, x} + {13'd0, speed};
  assign y_sum = {1'b0, y} + {13'd0, speed};
  assign x_lo  = {1'b0, X_MIN} + {13'd0, speed};
  assign y_lo  = {1'b0, Y_MIN} + {13'd0, speed};

  always_comb begin
    state_nx = state;
    x_nx     = x;
    y_nx     = y;
    speed_nx = speed;
    fcnt_nx  = fcnt;
    if (tick) begin
      if (hold) begin
        state_nx = HOLD;
        speed_nx = 4'd1;
        fcnt_nx  = '0;
      end else if (!(xinc | xdec | yinc | ydec)) begin
        state_nx = IDLE;
        speed_nx = 4'd1;
        fcnt_nx  = '0;
      end else begin
        state_nx = MOVING;
        if (xinc)
          x_nx = (x_sum > {1'b0, X_MAX}) ? X_MAX : x_sum[15:0];
        else if (xdec)
          x_nx = ({1'b0, x} < x_lo) ? X_MIN : x - {12'd0, speed};
        if (yinc)
          y_nx = (y_sum > {1'b0, Y_MAX}) ? Y_MAX : y_sum[15:0];
        else if (ydec)
          y_nx = ({1'b0, y} < y_lo) ? Y_MIN : y - {12'd0, speed};
        if (fcnt == ACCEL_FRAMES - 4'd1) begin
          fcnt_nx  = '0;
          speed_nx = (speed >= STEP_MAX) ? STEP_MAX : speed + 4'd1;
        end else begin
          fcnt_nx = fcnt + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      vsync_d    <= 1'b1;
      frame_tick <= 1'b0;
      x          <= X_INIT;
      y          <= Y_INIT;
      speed      <= 4'd1;
      fcnt       <= '0;
    end else begin
      state      <= state_nx;
      vsync_d    <= vsync;
      frame_tick <= tick;
      x          <= x_nx;
      y          <= y_nx;
      speed      <= speed_nx;
      fcnt       <= fcnt_nx;
    end
  end

  assign moving = (state == MOVING);

endmodule

// File: doc/map_position_ctrl.md
# map_position_ctrl

Generates the sprite/map centre coordinates `x`, `y` consumed by the map address stage. The block sits directly upstream of that stage. It samples four direction buttons once per video frame and moves the position with a speed that ramps while a button is held. The result is clamped so the 70x50 sprite stays fully on the 1024x768 screen. Coordinates change only at the start of vertical sync, so they are stable throughout active video.

## Interface
Parameters:
- `X_INIT`, 16'd512: x after reset.
- `Y_INIT`, 16'd384: y after reset.
- `X_MIN`, 16'd35: lowest legal x (sprite half-width).
- `X_MAX`, 16'd988: highest legal x (1024-36).
- `Y_MIN`, 16'd25: lowest legal y (sprite half-height).
- `Y_MAX`, 16'd742: highest legal y (768-26).
- `STEP_MAX`, 4'd8: maximum pixels moved per frame.
- `ACCEL_FRAMES`, 4'd4: consecutive moving frames per speed increment; must be ≥1.

Ports:
- `clk`, in, 1: pixel clock (65 MHz); all logic on the rising edge.
- `reset`, in, 1: asynchronous, active-high; all state goes to its reset values immediately.
- `vsync`, in, 1: active-low vertical sync from the XVGA timing generator, same clock domain.
- `up`, `down`, `left`, `right`, in, 1 each: debounced buttons, active-high.
- `hold`, in, 1: freeze position while high.
- `x`, out, 16: horizontal centre; reset `X_INIT`.
- `y`, out, 16: vertical centre; reset `Y_INIT`.
- `frame_tick`, out, 1: one-cycle pulse per frame; reset 0.
- `moving`, out, 1: high while in MOVING state; reset 0.

## Operation
Frame detection:
- Register `vsync` into `vsync_d` (reset 1).
- `tick` = `vsync_d & ~vsync`, i.e. a falling edge.
- There is exactly one tick per vsync low pulse, regardless of pulse length.

Axis direction, evaluated at each tick:
- Horizontal: `right & ~left` → +1; `left & ~right` → -1; otherwise 0.
- Vertical: `down & ~up` → +1; `up & ~down` → -1; otherwise 0.
- `active` = either axis direction is non-zero.

State machine: states IDLE, MOVING, HOLD.
- Internal registers: `speed` (4 bits, reset 1) and `fcnt` (4 bits, reset 0). The reset state is IDLE.
- Any state, `hold`=1 at a tick → go to HOLD. Position is unchanged, `speed`←1, `fcnt`←0.
- IDLE/MOVING/HOLD, `hold`=0 and `active`=0 at a tick → go to IDLE. Position is unchanged, `speed`←1, `fcnt`←0.
- IDLE/MOVING/HOLD, `hold`=0 and `active`=1 at a tick → go to MOVING and move each non-zero axis by the current `speed`. Coming from IDLE or HOLD, `speed` is already 1.
- Speed ramp, applied in the same update as the move:
  - If `fcnt` = `ACCEL_FRAMES`-1: `fcnt`←0 and `speed`←min(`speed`+1, `STEP_MAX`).
  - Otherwise `fcnt`←`fcnt`+1.
- Between ticks, all state is held.

Clamping: unsigned 16-bit arithmetic with no wrap-around.
- +1 direction: if `x`+`speed` > `X_MAX`, then `x`←`X_MAX`; otherwise `x`←`x`+`speed`. Compute the sum 17 bits wide.
- -1 direction: if `x` < `X_MIN`+`speed`, then `x`←`X_MIN`; otherwise `x`←`x`-`speed`.
- `y` follows the same rules using `Y_MIN`/`Y_MAX`.
- Clamping does not reset `speed` or change the state.

`moving` is 1 exactly when the state is MOVING.

## Timing
- Cycle N is the first cycle with `vsync`=0 while `vsync_d`=1.
- At the rising edge that ends cycle N:
  - `frame_tick`←1;
  - `x`, `y`, `speed`, `fcnt`, state and `moving` update together;
  - buttons and `hold` are sampled from cycle N.
- At the next edge `frame_tick`←0, so the output latency is 1 cycle from the vsync fall.
- Button changes between ticks have no effect.
- Reset asserted mid-ramp: all registers return to reset values at once. The first tick after release behaves as if coming from IDLE.
- Reset asserted while `vsync` is low: `vsync_d`=1 after reset, so a tick fires on the first cycle after release if `vsync` is still low.

## Test plan
- Reset, then one frame with `right`=1 → `x`=513, `y`=384, `frame_tick` high for exactly 1 cycle, `moving`=1.
- `right` held for 10 frames with defaults → per-frame steps 1,1,1,1,2,2,2,2,3,3; final `x`=530.
- `left`=`right`=1 with `up`=1 → `x` unchanged; `y` decrements 1 per frame; `moving`=1.
- `x`=987 with `speed`=3 and `right` held → `x`=988 next frame and stays at 988 on later frames; `left` from `x`=36 with `speed`≥2 → `x`=35.
- During a ramp at `speed`=3: assert `hold` → x/y frozen, `moving`=0. Release `hold` with `right` still held → next step is 1.
- `vsync` held low for 500 cycles → exactly one `frame_tick`. Reset pulsed mid-ramp → `x`=512, `y`=384, `speed`=1 immediately.
